ps2_kbd_reg: RTL

PS2_KBD_REG -- requirements
Module: ps2_kbd_reg

---
 rtl/hack_kbd_pkg.sv | 63 ++++++
 rtl/ps2_rx.sv | 87 ++++++++
 rtl/ps2_kbd_reg.sv | 101 ++++++++++
 3 files changed

// File: rtl/hack_kbd_pkg.sv
// Shared constants, state enums and the scan-set-2 to Hack key-code lookup
// for the PS/2 keyboard register.
package hack_kbd_pkg;

  localparam logic [7:0] PREFIX_EXT   = 8'hE0;
  localparam logic [7:0] PREFIX_BREAK = 8'hF0;
  localparam logic [7:0] SC_LSHIFT    = 8'h12;
  localparam logic [7:0] SC_RSHIFT    = 8'h59;

  localparam logic [15:0] KEY_SPACE = 16'd32;
  localparam logic [15:0] KEY_ENTER = 16'd128;
  localparam logic [15:0] KEY_BKSP  = 16'd129;
  localparam logic [15:0] KEY_LEFT  = 16'd130;
  localparam logic [15:0] KEY_UP    = 16'd131;
  localparam logic [15:0] KEY_RIGHT = 16'd132;
  localparam logic [15:0] KEY_DOWN  = 16'd133;
  localparam logic [15:0] KEY_HOME  = 16'd134;
  localparam logic [15:0] KEY_END   = 16'd135;
  localparam logic [15:0] KEY_PGUP  = 16'd136;
  localparam logic [15:0] KEY_PGDN  = 16'd137;
  localparam logic [15:0] KEY_INS   = 16'd138;
  localparam logic [15:0] KEY_DEL   = 16'd139;
  localparam logic [15:0] KEY_ESC   = 16'd140;
  localparam logic [15:0] KEY_F1    = 16'd141;

  typedef enum logic [1:0] {RX_IDLE, RX_SHIFT, RX_CHECK} rx_state_e;
  typedef enum logic [1:0] {DEC_IDLE, DEC_EXT, DEC_BREAK, DEC_EXT_BREAK} dec_state_e;

  // Letters come back upper-case; 0 means the scan code has no Hack mapping.
  function automatic logic [15:0] scan_to_hack(input logic [7:0] sc, input logic ext);
    logic [15:0] c;
    c = '0;
    if (ext) begin
      case (sc)
        8'h6B: c = KEY_LEFT;  8'h75: c = KEY_UP;    8'h74: c = KEY_RIGHT; 8'h72: c = KEY_DOWN;
        8'h6C: c = KEY_HOME;  8'h69: c = KEY_END;   8'h7D: c = KEY_PGUP;  8'h7A: c = KEY_PGDN;
        8'h70: c = KEY_INS;   8'h71: c = KEY_DEL;
        default: c = '0;
      endcase
    end else begin
      case (sc)
        8'h1C: c = 16'd65; 8'h32: c = 16'd66; 8'h21: c = 16'd67; 8'h23: c = 16'd68;
        8'h24: c = 16'd69; 8'h2B: c = 16'd70; 8'h34: c = 16'd71; 8'h33: c = 16'd72;
        8'h43: c = 16'd73; 8'h3B: c = 16'd74; 8'h42: c = 16'd75; 8'h4B: c = 16'd76;
        8'h3A: c = 16'd77; 8'h31: c = 16'd78; 8'h44: c = 16'd79; 8'h4D: c = 16'd80;
        8'h15: c = 16'd81; 8'h2D: c = 16'd82; 8'h1B: c = 16'd83; 8'h2C: c = 16'd84;
        8'h3C: c = 16'd85; 8'h2A: c = 16'd86; 8'h1D: c = 16'd87; 8'h22: c = 16'd88;
        8'h35: c = 16'd89; 8'h1A: c = 16'd90;
        8'h45: c = 16'd48; 8'h16: c = 16'd49; 8'h1E: c = 16'd50; 8'h26: c = 16'd51;
        8'h25: c = 16'd52; 8'h2E: c = 16'd53; 8'h36: c = 16'd54; 8'h3D: c = 16'd55;
        8'h3E: c = 16'd56; 8'h46: c = 16'd57;
        8'h29: c = KEY_SPACE; 8'h5A: c = KEY_ENTER; 8'h66: c = KEY_BKSP; 8'h76: c = KEY_ESC;
        8'h05: c = KEY_F1;          8'h06: c = KEY_F1 + 16'd1;  8'h04: c = KEY_F1 + 16'd2;
        8'h0C: c = KEY_F1 + 16'd3;  8'h03: c = KEY_F1 + 16'd4;  8'h0B: c = KEY_F1 + 16'd5;
        8'h83: c = KEY_F1 + 16'd6;  8'h0A: c = KEY_F1 + 16'd7;  8'h01: c = KEY_F1 + 16'd8;
        8'h09: c = KEY_F1 + 16'd9;  8'h78: c = KEY_F1 + 16'd10; 8'h07: c = KEY_F1 + 16'd11;
        default: c = '0;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchronizers, start/8 data/parity/stop capture,
// frame check and inter-edge timeout. Presents byte + valid + err.
module ps2_rx
  import hack_kbd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       byte_err_o
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]    clk_sync_q, data_sync_q;
  logic          clk_prev_q;
  rx_state_e     state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    shift_q, shift_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic          fall, din, timeout, frame_ok;

  assign fall     = clk_prev_q & ~clk_sync_q[1];
  assign din      = data_sync_q[1];
  assign timeout  = (state_q == RX_SHIFT) && !fall && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
  // shift_q holds {stop, parity, d7..d0}; odd parity means the XOR over data+parity is 1
  assign frame_ok = (^shift_q[8:0]) & shift_q[9];

  assign byte_o       = shift_q[7:0];
  assign byte_valid_o = (state_q == RX_CHECK) && frame_ok;
  assign byte_err_o   = ((state_q == RX_CHECK) && !frame_ok) || timeout;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    to_cnt_d  = (fall || state_q == RX_IDLE) ? '0 : to_cnt_q + 1'b1;
    case (state_q)
      RX_IDLE: begin
        if (fall && !din) begin
          state_d   = RX_SHIFT;
          bit_cnt_d = '0;
          shift_d   = '0;
        end
      end
      RX_SHIFT: begin
        if (timeout) begin
          state_d   = RX_IDLE;
          bit_cnt_d = '0;
        end else if (fall) begin
          shift_d   = {din, shift_q[9:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 4'd9) state_d = RX_CHECK;
        end
      end
      default: begin
        state_d   = RX_IDLE;
        bit_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
      state_q     <= RX_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      to_cnt_q    <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      clk_prev_q  <= clk_sync_q[1];
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

endmodule

// File: rtl/ps2_kbd_reg.sv
// PS/2 keyboard to Hack KBD register: decodes E0/F0 sequences into the code of
// the held key. Define KBD_SHIFT_EN to track shift (lower-case letters, digit symbols).
module ps2_kbd_reg
  import hack_kbd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] kbd_out,
  output logic        key_strobe,
  output logic        frame_err
);

  logic [7:0]  rx_byte;
  logic        rx_valid, rx_err;
  logic [15:0] kbd_q, kbd_d, code;
  logic        strobe_q, strobe_d, err_q, err_d, ext, brk;
  dec_state_e  dec_q, dec_d;
`ifdef KBD_SHIFT_EN
  logic        shift_q, shift_d;
`endif

  ps2_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
    .clk          (clk),
    .rst_n        (rst_n),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_valid),
    .byte_err_o   (rx_err)
  );

  always_comb begin
    kbd_d = kbd_q;
    dec_d = dec_q;
    err_d = rx_err;
    ext   = (dec_q == DEC_EXT) || (dec_q == DEC_EXT_BREAK);
    brk   = (dec_q == DEC_BREAK) || (dec_q == DEC_EXT_BREAK);
    code  = scan_to_hack(rx_byte, ext);
`ifdef KBD_SHIFT_EN
    shift_d = shift_q;
    if (code >= 16'd65 && code <= 16'd90 && !shift_q) begin
      code = code + 16'd32;
    end else if (shift_q && !ext) begin
      case (rx_byte)
        8'h45: code = 16'd41; 8'h16: code = 16'd33; 8'h1E: code = 16'd64; 8'h26: code = 16'd35;
        8'h25: code = 16'd36; 8'h2E: code = 16'd37; 8'h36: code = 16'd94; 8'h3D: code = 16'd38;
        8'h3E: code = 16'd42; 8'h46: code = 16'd40;
        default: ;
      endcase
    end
`endif
    if (rx_valid) begin
      if (rx_byte == PREFIX_EXT) begin
        dec_d = DEC_EXT;
      end else if (rx_byte == PREFIX_BREAK) begin
        dec_d = ext ? DEC_EXT_BREAK : DEC_BREAK;
      end else begin
        dec_d = DEC_IDLE;
`ifdef KBD_SHIFT_EN
        if (!ext && (rx_byte == SC_LSHIFT || rx_byte == SC_RSHIFT)) shift_d = !brk;
`endif
        // A break only clears the register when it releases the key being shown
        if (brk) begin
          if (code != '0 && code == kbd_q) kbd_d = '0;
        end else if (code != '0) begin
          kbd_d = code;
        end
      end
    end
    strobe_d = (kbd_d != kbd_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kbd_q    <= '0;
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
      dec_q    <= DEC_IDLE;
`ifdef KBD_SHIFT_EN
      shift_q  <= 1'b0;
`endif
    end else begin
      kbd_q    <= kbd_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
      dec_q    <= dec_d;
`ifdef KBD_SHIFT_EN
      shift_q  <= shift_d;
`endif
    end
  end

  assign kbd_out    = kbd_q;
  assign key_strobe = strobe_q;
  assign frame_err  = err_q;

endmodule
